// File: rtl/lcd_byte_writer_pkg.sv
// Shared types, state encoding and default timing for the LCD byte writer.
// Defaults are in 50 MHz cycles.
package lcd_byte_writer_pkg;

  typedef enum logic [3:0] {
    LCDW_IDLE,
    LCDW_HI_SETUP,
    LCDW_HI_PULSE,
    LCDW_HI_HOLD,
    LCDW_GAP,
    LCDW_LO_SETUP,
    LCDW_LO_PULSE,
    LCDW_LO_HOLD,
    LCDW_SETTLE
  } lcdw_state_e;

  localparam int unsigned DEF_SETUP_CYC     = 2;
  localparam int unsigned DEF_PULSE_CYC     = 12;
  localparam int unsigned DEF_HOLD_CYC      = 1;
  localparam int unsigned DEF_GAP_CYC       = 50;
  localparam int unsigned DEF_WAIT_CYC      = 2000;
  localparam int unsigned DEF_LONG_WAIT_CYC = 82000;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcdw_req_t;

  // Clear (0x01) and Home (0x02/0x03) need the long settle.
  function automatic logic is_long_cmd(input lcdw_req_t r);
    return !r.rs && (r.data == 8'h01 || r.data == 8'h02 || r.data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte write handshake between the instruction pipeline and the LCD writer.
interface lcd_byte_writer_if;
  logic       write;
  logic       rs;
  logic [7:0] data;
  logic       ready;

  modport master (output write, rs, data, input ready);
  modport slave  (input write, rs, data, output ready);
endinterface

// File: rtl/lcd_byte_writer_delay_counter.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module lcd_byte_writer_delay_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/lcd_byte_writer.sv
// Serialises one byte onto the 4-bit LCD bus as two E-strobed nibbles,
// then settles before signalling ready again.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC       = DEF_GAP_CYC,
  parameter int unsigned WAIT_CYC      = DEF_WAIT_CYC,
  parameter int unsigned LONG_WAIT_CYC = DEF_LONG_WAIT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_byte_writer_if.slave   bus,
  output logic               lcd_e,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic [3:0]         lcd_data,
  output logic               lcd_sf_ctrl
);
  // Long settle is the largest duration, so it sets the counter width.
  localparam int CW = (LONG_WAIT_CYC > 1) ? $clog2(LONG_WAIT_CYC + 1) : 1;

  lcdw_state_e state, nxt;
  lcdw_req_t   req_q, req_in, src;
  logic        long_q;
  logic        cnt_zero, cnt_load;
  logic [CW-1:0] cnt_val;
  logic        nxt_e, nxt_rs;
  logic [3:0]  nxt_data;

  function automatic logic [CW-1:0] dur(input lcdw_state_e s, input logic lng);
    case (s)
      LCDW_HI_SETUP, LCDW_LO_SETUP: dur = CW'(SETUP_CYC - 1);
      LCDW_HI_PULSE, LCDW_LO_PULSE: dur = CW'(PULSE_CYC - 1);
      LCDW_HI_HOLD,  LCDW_LO_HOLD:  dur = CW'(HOLD_CYC - 1);
      LCDW_GAP:                     dur = CW'(GAP_CYC - 1);
      LCDW_SETTLE:                  dur = lng ? CW'(LONG_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);
      default:                      dur = '0;
    endcase
  endfunction

  lcd_byte_writer_delay_counter #(.W(CW)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LCDW_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt         = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    req_in.rs   = bus.rs;
    req_in.data = bus.data;
    case (state)
      LCDW_IDLE:     if (bus.write) nxt = LCDW_HI_SETUP;
      LCDW_HI_SETUP: if (cnt_zero)  nxt = LCDW_HI_PULSE;
      LCDW_HI_PULSE: if (cnt_zero)  nxt = LCDW_HI_HOLD;
      LCDW_HI_HOLD:  if (cnt_zero)  nxt = LCDW_GAP;
      LCDW_GAP:      if (cnt_zero)  nxt = LCDW_LO_SETUP;
      LCDW_LO_SETUP: if (cnt_zero)  nxt = LCDW_LO_PULSE;
      LCDW_LO_PULSE: if (cnt_zero)  nxt = LCDW_LO_HOLD;
      LCDW_LO_HOLD:  if (cnt_zero)  nxt = LCDW_SETTLE;
      LCDW_SETTLE:   if (cnt_zero)  nxt = LCDW_IDLE;
      default:                      nxt = LCDW_IDLE;
    endcase
    if (nxt != state) begin
      cnt_load = 1'b1;
      cnt_val  = dur(nxt, long_q);
    end

    // On acceptance the byte is not latched yet, so drive from the bus.
    src      = (state == LCDW_IDLE) ? req_in : req_q;
    nxt_e    = (nxt == LCDW_HI_PULSE) || (nxt == LCDW_LO_PULSE);
    nxt_data = lcd_data;
    nxt_rs   = lcd_rs;
    case (nxt)
      LCDW_HI_SETUP, LCDW_HI_PULSE, LCDW_HI_HOLD: begin
        nxt_data = src.data[7:4];
        nxt_rs   = src.rs;
      end
      LCDW_LO_SETUP, LCDW_LO_PULSE, LCDW_LO_HOLD: begin
        nxt_data = src.data[3:0];
        nxt_rs   = src.rs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      long_q <= 1'b0;
    end else if (state == LCDW_IDLE && bus.write) begin
      req_q  <= req_in;
      long_q <= is_long_cmd(req_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready   <= 1'b1;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_data    <= 4'h0;
      lcd_sf_ctrl <= 1'b1;
    end else begin
      bus.ready   <= (nxt == LCDW_IDLE);
      lcd_e       <= nxt_e;
      lcd_rs      <= nxt_rs;
      lcd_rw      <= 1'b0;
      lcd_data    <= nxt_data;
      lcd_sf_ctrl <= 1'b1;
    end
  end
endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Downstream transfer stage between the MiniAlu `LCD` instruction path and the Spartan-3E character LCD pins. Accepts one byte plus a register-select flag per handshake and serialises it onto the 4-bit LCD bus as two nibble transfers with enable-pulse setup, hold and settle timing. Reports busy/ready back to the instruction pipeline so the IP counter can stall. Used after power-on initialisation is complete; the init sequence itself is out of scope.

## Interface
Parameters:
- SETUP_CYC, 2, cycles RS/data stable before E rises (≥40 ns at 50 MHz)
- PULSE_CYC, 12, E high cycles (≥230 ns)
- HOLD_CYC, 1, cycles RS/data held after E falls
- GAP_CYC, 50, cycles between upper and lower nibble (≥1 µs)
- WAIT_CYC, 2000, settle after a normal byte (≥40 µs)
- LONG_WAIT_CYC, 82000, settle after Clear (0x01) or Home (0x02/0x03) commands (≥1.64 ms)

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low
- iWrite  in  1  write request, qualified by oReady
- iRS  in  1  0 = command, 1 = data
- iData  in  8  byte to transfer
- oReady  out  1  high = idle, request accepted this cycle
- oLCD_E  out  1  LCD enable
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  constant 0 (write only)
- oLCD_Data  out  4  LCD data nibble
- oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled)

## Operation
- All outputs registered. Reset values: oReady=1, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=4'h0, oLCD_StrataFlashControl=1, state IDLE, counter 0.
- States: IDLE → HI_SETUP → HI_PULSE → HI_HOLD → GAP → LO_SETUP → LO_PULSE → LO_HOLD → SETTLE → IDLE.
- IDLE: oReady=1. On a clock edge with iWrite=1, latch iRS and iData, select settle length, enter HI_SETUP, oReady=0.
- Long settle selected when iRS=0 and iData ∈ {8'h01, 8'h02, 8'h03}; otherwise WAIT_CYC.
- HI_*: oLCD_Data=iData[7:4]. LO_*: oLCD_Data=iData[3:0]. oLCD_RS = latched iRS from HI_SETUP through LO_HOLD.
- oLCD_E=1 only in HI_PULSE and LO_PULSE.
- GAP and SETTLE: oLCD_E=0, data/RS hold their last values.
- Each timed state lasts exactly its parameter count in cycles. The counter loads N-1 on entry and the state advances when the count reaches 0.
- iWrite while oReady=0 is ignored (no queueing, no error). iData and iRS are not required to be held after acceptance.
- Reset asserted mid-transfer: asynchronously forces oLCD_E=0 and all reset values. The partial nibble is abandoned.
- Counter width is sized from LONG_WAIT_CYC (17 bits at default). Parameter values ≥1 are required; a value of 0 is illegal.

## Timing
- Request accepted at edge T → oReady=0 and HI_SETUP visible from T+1.
- First E rise at T+1+SETUP_CYC.
- Second E rise at T+1+2·SETUP_CYC+PULSE_CYC+HOLD_CYC+GAP_CYC.
- oReady returns to 1 at T+1+2·(SETUP+PULSE+HOLD)+GAP+settle. At defaults this is T+2081 for a normal byte and T+82081 for clear/home.
- A new iWrite may be accepted on the first edge where oReady=1. Back-to-back bytes have zero extra idle cycles.
- oReady is registered. The upstream IP stall uses it combinationally in the same cycle.

## Structure
- Shared `Defintions.v` carries the state encodings (`LCDW_IDLE` … `LCDW_SETTLE`) and default timing constants, alongside the existing opcode defines.
- One natural sub-module: `lcd_delay_counter`, a loadable down-counter with a zero flag, parameterised by width. The FSM instantiates it once.
- The existing `LCD` init FSM hands the bus to this block after init through an external mux owned by MiniAlu. No mux is inside this block.

## Test plan
- Reset then idle: all outputs at reset values, oReady=1, no E pulses over 100 cycles.
- Data write iRS=1, iData=8'h41: Data=4'h4 with RS=1 while E is high for 12 cycles starting at T+3. Then Data=4'h1 with E high for 12 cycles starting at T+68. oReady=1 at T+2081.
- Command 8'h01 with iRS=0: RS=0 on both nibbles; oReady stays 0 until T+82081. Command 8'h28: oReady returns at T+2081.
- iWrite held high continuously with changing iData: only the bytes present at the ready edges are transferred; no E pulses are missing or extra.
- Reset pulsed low during HI_PULSE: oLCD_E drops in the same cycle without a clock edge. oReady=1 after release and the next write proceeds normally.
- Back-to-back writes 8'h48, 8'h49: the second is accepted at the exact ready edge. Four E pulses total with correct nibbles and spacing.
